pll_reset_sequencer: RTL and testbench

// - Consumer end of the PLL lock interface: samples the asynchronous 'locked' output of the
//   PLL wrapper, qualifies it, and releases the system reset only after lock is stable.
// - Detects loss of lock, reasserts reset for a minimum hold time, records a sticky fault,
//   and flags a lock timeout. Runs on the free-running 12 MHz reference clock.

---
 rtl/pll_reset_sequencer_pkg.sv | 21 ++
 rtl/pll_reset_sequencer_if.sv | 34 +++
 rtl/pll_reset_sequencer_sync_ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 137 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Optional feature macro: LOCK_LOSS_COUNT_EN (lock-loss counter width lives here).
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock/reset signal bundle between the PLL side and the reset sequencer.
// Optional feature macro: LOCK_LOSS_COUNT_EN adds the lock_loss_count signal.
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic       locked;
  logic       clear_sticky;
  logic       sys_reset_n;
  logic       lock_lost_sticky;
  logic       timeout;
  logic [1:0] state;
`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] lock_loss_count;

  modport master (
    output locked, clear_sticky,
    input  sys_reset_n, lock_lost_sticky, timeout, state, lock_loss_count
  );
  modport slave (
    input  locked, clear_sticky,
    output sys_reset_n, lock_lost_sticky, timeout, state, lock_loss_count
  );
`else
  modport master (
    output locked, clear_sticky,
    input  sys_reset_n, lock_lost_sticky, timeout, state
  );
  modport slave (
    input  locked, clear_sticky,
    output sys_reset_n, lock_lost_sticky, timeout, state
  );
`endif

endinterface

// File: rtl/pll_reset_sequencer_sync_ff.sv
// N-flop synchronizer for a single asynchronous level, reset to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock and releases system reset only after lock has been stable.
// Optional feature macro: LOCK_LOSS_COUNT_EN enables the saturating lock-loss counter.
//
//   state     | meaning
//   WAIT_LOCK | waiting for synchronized lock; counts toward timeout
//   STABILIZE | lock seen, must stay high STABLE_CYCLES before release
//   RUN       | system reset released
//   HOLD      | lock lost, reset held for HOLD_CYCLES
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 1200,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                 i_clock_in,
  input  logic                 i_reset_n,
  pll_reset_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = max3(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lock_s;
  logic             w_loss;
  logic             w_set_timeout;
  logic             w_enter_run;
  logic             r_sys_reset_n;
  logic             r_sticky;
  logic             r_timeout;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk   (i_clock_in),
    .i_rst_n (i_reset_n),
    .i_d     (bus.locked),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_loss        = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = STABILIZE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_set_timeout = 1'b1;
        end
      end
      STABILIZE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = HOLD;
          w_loss      = 1'b1;
        end
      end
      HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = WAIT_LOCK;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase

    w_enter_run = (w_state_nxt == RUN) && (r_state != RUN);

    // One shared counter: restarts on every state change, idles at 0 in RUN
    if ((w_state_nxt != r_state) || (r_state == RUN)) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != '1) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_ff @(posedge i_clock_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= WAIT_LOCK;
      r_cnt         <= '0;
      r_sys_reset_n <= 1'b0;
      r_sticky      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sys_reset_n <= (w_state_nxt == RUN);
      if (w_loss) begin
        r_sticky <= 1'b1;
      end else if (bus.clear_sticky) begin
        r_sticky <= 1'b0;
      end
      if (w_enter_run) begin
        r_timeout <= 1'b0;
      end else if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge i_clock_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign bus.lock_loss_count = r_loss_cnt;
`endif

  assign bus.sys_reset_n      = r_sys_reset_n;
  assign bus.lock_lost_sticky = r_sticky;
  assign bus.timeout          = r_timeout;
  assign bus.state            = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed + randomized bench for pll_reset_sequencer against a cycle-level behavioural model.
// Count checks are compiled in only with LOCK_LOSS_COUNT_EN.
module tb_pll_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD_C = 4;
  localparam int TMO    = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .STABLE_CYCLES  (STABLE),
    .HOLD_CYCLES    (HOLD_C),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock_in (clk),
    .i_reset_n  (rst_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: delay line of raw samples, current phase, and cycles spent in that phase
  bit lock_q[$];
  int m_phase;
  int m_elapsed;
  bit m_sticky;
  bit m_timeout;
  int m_losses;

  function automatic void model_reset();
    lock_q = {};
    for (int i = 0; i < SYNC; i++) lock_q.push_back(1'b0);
    m_phase   = 0;
    m_elapsed = 0;
    m_sticky  = 1'b0;
    m_timeout = 1'b0;
    m_losses  = 0;
  endfunction

  function automatic void model_edge(input bit lk, input bit clr);
    bit seen;
    bit loss;
    seen = lock_q[0];
    loss = 1'b0;
    case (m_phase)
      0: begin
        if (seen) begin
          m_phase = 1; m_elapsed = 0;
        end else begin
          if (m_elapsed == TMO - 1) m_timeout = 1'b1;
          m_elapsed++;
        end
      end
      1: begin
        if (!seen) begin
          m_phase = 0; m_elapsed = 0;
        end else if (m_elapsed == STABLE - 1) begin
          m_phase = 2; m_elapsed = 0; m_timeout = 1'b0;
        end else begin
          m_elapsed++;
        end
      end
      2: begin
        if (!seen) begin
          m_phase = 3; m_elapsed = 0; loss = 1'b1;
        end
      end
      default: begin
        if (m_elapsed == HOLD_C - 1) begin
          m_phase = 0; m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
    endcase
    if (loss) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    if (loss && m_losses < 255) m_losses++;
    lock_q.push_back(lk);
    while (lock_q.size() > SYNC) void'(lock_q.pop_front());
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    check("model_state", {30'd0, bus.state}, m_phase);
    check("model_sys_reset_n", {31'd0, bus.sys_reset_n}, (m_phase == 2) ? 1 : 0);
    check("model_sticky", {31'd0, bus.lock_lost_sticky}, m_sticky);
    check("model_timeout", {31'd0, bus.timeout}, m_timeout);
`ifdef LOCK_LOSS_COUNT_EN
    check("model_count", {24'd0, bus.lock_loss_count}, m_losses);
`endif
  endtask

  task automatic step(input bit lk, input bit clr);
    bus.locked       = lk;
    bus.clear_sticky = clr;
    @(posedge clk);
    model_edge(lk, clr);
    #1;
    compare_model();
  endtask

  initial begin
    int len;
    bit lk;
    bus.locked       = 1'b0;
    bus.clear_sticky = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("reset_sys_reset_n", {31'd0, bus.sys_reset_n}, 0);
    check("reset_state", {30'd0, bus.state}, 0);
    check("reset_sticky", {31'd0, bus.lock_lost_sticky}, 0);
    check("reset_timeout", {31'd0, bus.timeout}, 0);
`ifdef LOCK_LOSS_COUNT_EN
    check("reset_count", {24'd0, bus.lock_loss_count}, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();

    // Timeout: edges numbered from the first edge after reset release
    for (int i = 1; i <= TMO; i++) begin
      step(1'b0, 1'b0);
      if (i == TMO - 1) check("timeout_before_50", {31'd0, bus.timeout}, 0);
      if (i == TMO)     check("timeout_at_50", {31'd0, bus.timeout}, 1);
    end

    // Clean lock: locked rises right after edge 0, release exactly at edge 11
    for (int i = 1; i <= 11; i++) begin
      step(1'b1, 1'b0);
      if (i == 10) check("lock_edge10_still_reset", {31'd0, bus.sys_reset_n}, 0);
      if (i == 11) begin
        check("lock_edge11_release", {31'd0, bus.sys_reset_n}, 1);
        check("lock_edge11_state", {30'd0, bus.state}, 2);
        check("lock_edge11_sticky", {31'd0, bus.lock_lost_sticky}, 0);
        check("lock_edge11_timeout_cleared", {31'd0, bus.timeout}, 0);
      end
    end

    // Loss in RUN: first sampled at edge 1, reset drops two edges after that
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0);
      if (i == 2) check("loss_not_yet", {31'd0, bus.sys_reset_n}, 1);
      if (i == 3) begin
        check("loss_sys_reset_n", {31'd0, bus.sys_reset_n}, 0);
        check("loss_state_hold", {30'd0, bus.state}, 3);
        check("loss_sticky", {31'd0, bus.lock_lost_sticky}, 1);
`ifdef LOCK_LOSS_COUNT_EN
        check("loss_count", {24'd0, bus.lock_loss_count}, 1);
`endif
      end
      if (i == 6) check("hold_last_cycle", {30'd0, bus.state}, 3);
      if (i == 7) check("hold_exit", {30'd0, bus.state}, 0);
    end

    step(1'b0, 1'b1);
    check("lone_clear", {31'd0, bus.lock_lost_sticky}, 0);
    step(1'b0, 1'b0);

    // Glitch: five cycles high then low
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) check("glitch_stabilize", {30'd0, bus.state}, 1);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0);
      if (i == 3) begin
        check("glitch_back_to_wait", {30'd0, bus.state}, 0);
        check("glitch_sys_reset_n", {31'd0, bus.sys_reset_n}, 0);
        check("glitch_sticky", {31'd0, bus.lock_lost_sticky}, 0);
      end
    end

    for (int i = 1; i <= 11; i++) step(1'b1, 1'b0);
    check("relock_run", {30'd0, bus.state}, 2);

    // Sticky race: clear pulse lands on the loss edge
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("race_sticky_wins", {31'd0, bus.lock_lost_sticky}, 1);
`ifdef LOCK_LOSS_COUNT_EN
    check("race_count", {24'd0, bus.lock_loss_count}, 2);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("race_later_clear", {31'd0, bus.lock_lost_sticky}, 0);

    // Randomized runs of lock/unlock with sporadic clear pulses
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 14);
      lk  = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) step(lk, ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("pre_async_run", {30'd0, bus.state}, 2);

    // Async reset mid-cycle while in RUN
    #3 rst_n = 1'b0;
    #1;
    check("async_sys_reset_n", {31'd0, bus.sys_reset_n}, 0);
    check("async_state", {30'd0, bus.state}, 0);
    check("async_sticky", {31'd0, bus.lock_lost_sticky}, 0);
    check("async_timeout", {31'd0, bus.timeout}, 0);
`ifdef LOCK_LOSS_COUNT_EN
    check("async_count", {24'd0, bus.lock_loss_count}, 0);
`endif
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
